// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the fetch stage (IF) and the
// load/store stage (MEM). At most one access is granted per cycle. Data
// normally wins a conflict, and if_stall tells the pipeline to hold the PC.
// Read data comes back one cycle after the grant, tagged with if_valid or
// dm_valid.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the starvation
// guard. After STARVE_LIMIT consecutive refused fetch cycles, fetch wins the
// next conflict. Without the macro there is strict data priority and no
// counter.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request and PC
//   if_gnt/if_stall                 fetch grant / refusal (combinational)
//   if_valid/if_rdata               fetched word, one cycle after if_gnt
//   dm_req/dm_we/dm_addr/dm_wdata   load/store request
//   dm_gnt                          data grant (combinational)
//   dm_valid/dm_rdata               load data, one cycle after a load grant
//   mem_en/mem_we/mem_addr/mem_wdata  memory macro drive
//   mem_rdata                       memory read data (cycle after read strobe)
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              fetch_wins_s;
  logic [DATA_W-1:0] if_hold_r;
  logic [DATA_W-1:0] dm_hold_r;

  // The 4-bit starvation counter cannot represent a limit outside 1..15.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_r;

  assign fetch_wins_s = (starve_cnt_r == LIMIT);

  // Count consecutive refused fetch cycles, saturating at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt_r != 4'hF) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end
`else
  assign fetch_wins_s = 1'b0;
`endif

  // Grant decision: data first, unless the starvation guard hands fetch the slot.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst_n) begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end else if (if_req && (!dm_req || fetch_wins_s)) begin
      if_gnt = 1'b1;
    end else if (dm_req) begin
      dm_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  assign if_stall = if_req & ~if_gnt;

  // Route the granted requester onto the memory port; idle drives all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response owner register: remembers whose read is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next owner depends only on this cycle's grant. Every state uses the same
  // transitions, so back-to-back reads run at full rate.
  always_comb begin
    state_nxt_s = IDLE;
    if (if_gnt) begin
      state_nxt_s = RD_IF;
    end else if (dm_gnt && !dm_we) begin
      state_nxt_s = RD_DM;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Response outputs: the owning port sees memory data live, the other port holds.
  always_comb begin
    if_valid = 1'b0;
    dm_valid = 1'b0;
    if_rdata = if_hold_r;
    dm_rdata = dm_hold_r;
    case (state_r)
      RD_IF: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      RD_DM: begin
        dm_valid = 1'b1;
        dm_rdata = mem_rdata;
      end
      default: begin
        if_valid = 1'b0;
        dm_valid = 1'b0;
      end
    endcase
  end

  // Hold registers keep the last delivered word on each port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_hold_r <= {DATA_W{1'b0}};
      dm_hold_r <= {DATA_W{1'b0}};
    end else begin
      if (state_r == RD_IF) begin
        if_hold_r <= mem_rdata;
      end
      if (state_r == RD_DM) begin
        dm_hold_r <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LIMIT = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic if_gnt, if_stall, if_valid, dm_gnt, dm_valid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    case (i)
      0: w = 16'hFFFF;
      1: w = 16'h3301;
      2: w = 16'h3412;
      3: w = 16'h12A8;
      default: w = 16'((i * 40503) ^ 16'h5A5A);
    endcase
    return w;
  endfunction

  // Memory macro: one-cycle read latency; junk on the bus when not reading.
  logic [DW-1:0] mem_arr [0:1023];
  bit preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= DW'($urandom);
    end else if (mem_en) begin
      mem_rdata <= mem_arr[mem_addr[9:0]];
    end else begin
      mem_rdata <= DW'($urandom);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  typedef struct {
    bit if_gnt; bit dm_gnt; bit stall; bit en; bit we;
    logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } gexp_t;
  typedef struct { bit is_if; logic [DW-1:0] data; int due; } rsp_t;
  gexp_t gexp_q[$];
  rsp_t  rsp_q[$];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] last_if = '0, last_dm = '0;
  int refused = 0;
  bit last_fw = 1'b0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle and record what the specification says must happen.
  task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr,
                       input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    gexp_t g;
    rsp_t r;
    bit fw;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dw;
    fw = ir && (!dr || (GUARD && refused == LIMIT));
    g.if_gnt = fw;
    g.dm_gnt = dr && !fw;
    g.stall  = ir && !fw;
    g.en     = ir || dr;
    g.we     = dr && !fw && dwe;
    g.addr   = fw ? ia : (dr ? da : '0);
    g.wdata  = (dr && !fw) ? dw : '0;
    gexp_q.push_back(g);
    if (fw) begin
      r.is_if = 1'b1; r.data = ref_mem[ia[9:0]]; r.due = cyc + 1; rsp_q.push_back(r);
    end else if (dr && !dwe) begin
      r.is_if = 1'b0; r.data = ref_mem[da[9:0]]; r.due = cyc + 1; rsp_q.push_back(r);
    end else if (dr) begin
      ref_mem[da[9:0]] = dw;
    end
    if (ir && !fw) refused = (refused == 15) ? 15 : refused + 1;
    else refused = 0;
    last_fw = fw;
  endtask

  // Monitor: compare grants each cycle, and responses whenever a valid shows.
  always @(negedge clk) begin : monitor
    gexp_t g;
    rsp_t r;
    if (gexp_q.size() > 0) begin
      g = gexp_q.pop_front();
      chk("if_gnt", 32'(if_gnt), 32'(g.if_gnt));
      chk("dm_gnt", 32'(dm_gnt), 32'(g.dm_gnt));
      chk("if_stall", 32'(if_stall), 32'(g.stall));
      chk("mem_en", 32'(mem_en), 32'(g.en));
      chk("mem_we", 32'(mem_we), 32'(g.we));
      chk("mem_addr", 32'(mem_addr), 32'(g.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
    end
    if (if_valid || dm_valid) begin
      if (rsp_q.size() == 0) begin
        chk("spurious_valid", {30'd0, if_valid, dm_valid}, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(r.due));
        chk("rsp_if_valid", 32'(if_valid), 32'(r.is_if));
        chk("rsp_dm_valid", 32'(dm_valid), 32'(!r.is_if));
        if (r.is_if) last_if = r.data;
        else last_dm = r.data;
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      chk("missing_valid", 32'd0, r.is_if ? 32'd2 : 32'd1);
    end
    chk("if_rdata", 32'(if_rdata), 32'(last_if));
    chk("dm_rdata", 32'(dm_rdata), 32'(last_dm));
  end

  initial begin
    logic [4:0] if_pat, dm_pat, exp_if_pat, exp_dm_pat;
    bit pend, ir, dr, dwe;
    logic [AW-1:0] pa, ia, da;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    // Reset with both requests high: nothing may be granted or valid.
    if_req = 1'b1; dm_req = 1'b1; if_addr = 16'd3; dm_addr = 16'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid), 32'd0);
    preload = 1'b0;

    // Release: data wins in the first cycle; the refused fetch then goes.
    drive(1'b1, 16'd3, 1'b1, 1'b0, 16'd9, 16'h0);
    drive(1'b1, 16'd3, 1'b0, 1'b0, 16'd0, 16'h0);

    // Fetch-only burst over the preloaded words.
    for (int a = 0; a < 4; a++) drive(1'b1, AW'(a), 1'b0, 1'b0, 16'd0, 16'h0);

    // Conflict: fetch @5 against load @9, then the held fetch completes.
    drive(1'b1, 16'd5, 1'b1, 1'b0, 16'd9, 16'h0);
    drive(1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 16'h0);

    // Store then load back.
    drive(1'b0, 16'd0, 1'b1, 1'b1, 16'd20, 16'h00A5);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);
    drive(1'b0, 16'd0, 1'b1, 1'b0, 16'd20, 16'h0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);

    // Starvation: both held for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'd7, 1'b1, 1'b0, AW'(30 + k), 16'h0);
      @(negedge clk);
      if_pat[k] = if_gnt;
      dm_pat[k] = dm_gnt;
    end
    exp_if_pat = GUARD ? 5'b01000 : 5'b00000;
    exp_dm_pat = ~exp_if_pat;
    chk("starve_if_pattern", 32'(if_pat), 32'(exp_if_pat));
    chk("starve_dm_pattern", 32'(dm_pat), 32'(exp_dm_pat));
    drive(1'b1, 16'd7, 1'b0, 1'b0, 16'd0, 16'h0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);

    // Reset mid-read: the pending load response must never appear.
    drive(1'b0, 16'd0, 1'b1, 1'b0, 16'd12, 16'h0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    rsp_q.delete();
    last_if = '0; last_dm = '0; refused = 0;
    @(negedge clk);
    chk("midrst_dm_valid", 32'(dm_valid), 32'd0);
    chk("midrst_dm_rdata", 32'(dm_rdata), 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);

    // Randomised traffic; a refused fetch keeps its request and address.
    pend = 1'b0; pa = '0;
    for (int n = 0; n < 400; n++) begin
      ir  = pend ? 1'b1 : 1'($urandom_range(0, 1));
      ia  = pend ? pa : AW'($urandom_range(0, 63));
      dr  = 1'($urandom_range(0, 1));
      dwe = 1'($urandom_range(0, 2) == 0);
      da  = AW'($urandom_range(0, 63));
      drive(ir, ia, dr, dwe, da, DW'($urandom));
      pend = ir && !last_fw;
      pa = ia;
    end
    for (int n = 0; n < 3; n++) drive(pend, pa, 1'b0, 1'b0, 16'd0, 16'h0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("gnt_queue_drained", 32'(gexp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
